// File: rtl/id_pipe_stage.sv
// id_pipe_stage: buffered, pipelined RV64I/RV32I decode stage between IF and EX.
// Fetched inst/PC pairs queue in a small FIFO. The FIFO head is decoded
// combinationally and captured into a registered output slot.
// Optional feature: define ID_MEXT_EN to decode the M-extension (mul/div/rem).
// Without it, those encodings are flagged illegal and out_mul_info is tied to 0.
module id_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [13:0]     out_op_info,
  output logic [9:0]      out_alu_info,
  output logic [7:0]      out_mul_info,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rd_addr,
  output logic            out_rs1_ena,
  output logic            out_rs2_ena,
  output logic            out_rd_ena,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state, state_next;
  logic [31:0]     fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [13:0]     dec_op;
  logic [9:0]      dec_alu;
  logic [7:0]      dec_mul;
  logic            dec_rs1_ena, dec_rs2_ena, dec_rd_ena, dec_illegal;
  logic [XLEN-1:0] dec_imm;

  assign push = in_valid && in_ready;
  assign pop  = (count != '0) && (!out_valid || out_ready);

  assign head_inst = fifo_inst[rd_ptr];
  assign head_pc   = fifo_pc[rd_ptr];

  assign opcode = head_inst[6:0];
  assign funct3 = head_inst[14:12];
  assign funct7 = head_inst[31:25];

  assign imm_i = XLEN'($signed(head_inst[31:20]));
  assign imm_s = XLEN'($signed({head_inst[31:25], head_inst[11:7]}));
  assign imm_b = XLEN'($signed({head_inst[31], head_inst[7], head_inst[30:25],
                                head_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({head_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({head_inst[31], head_inst[19:12], head_inst[20],
                                head_inst[30:21], 1'b0}));

  // State register: a trap accepted at the input parks the stage in HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: flush always returns to RUN; a trap only counts if it really transfers
  always_comb begin
    state_next = state;
    if (flush)                                  state_next = RUN;
    else if (push && in_inst[6:0] == 7'h6b)     state_next = HALT;
  end

  // Input handshake: accept only while running and the FIFO has a free entry
  always_comb begin
    in_ready = !rst && (state == RUN) && (count < FULL_COUNT);
  end

  // FIFO storage: a push on a flush edge is dropped
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_inst[wr_ptr] <= in_inst;
      fifo_pc[wr_ptr]   <= in_pc;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Decode the FIFO head; illegal encodings lose their ALU/MUL class and rd write
  always_comb begin
    dec_op      = '0;
    dec_alu     = '0;
    dec_mul     = '0;
    dec_rs1_ena = 1'b0;
    dec_rs2_ena = 1'b0;
    dec_rd_ena  = 1'b0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opcode)
      7'h03: begin
        dec_op[0] = 1'b1; dec_rs1_ena = 1'b1; dec_rd_ena = 1'b1;
        dec_imm = imm_i; dec_alu[ALU_ADD] = 1'b1;
        if (funct3 == 3'd7) dec_illegal = 1'b1;
        if (XLEN == 32 && (funct3 == 3'd3 || funct3 == 3'd6)) dec_illegal = 1'b1;
      end
      7'h0f: begin
        dec_op[1] = 1'b1;
        if (funct3 != 3'd0) dec_illegal = 1'b1;
      end
      7'h13: begin
        dec_op[2] = 1'b1; dec_rs1_ena = 1'b1; dec_rd_ena = 1'b1; dec_imm = imm_i;
        case (funct3)
          3'd0: dec_alu[ALU_ADD]  = 1'b1;
          3'd2: dec_alu[ALU_SLT]  = 1'b1;
          3'd3: dec_alu[ALU_SLTU] = 1'b1;
          3'd4: dec_alu[ALU_XOR]  = 1'b1;
          3'd6: dec_alu[ALU_OR]   = 1'b1;
          3'd7: dec_alu[ALU_AND]  = 1'b1;
          3'd1: begin
            dec_alu[ALU_SLL] = 1'b1;
            if (funct7[6:1] != 6'h00) dec_illegal = 1'b1;
            if (XLEN == 32 && funct7[0]) dec_illegal = 1'b1;
          end
          default: begin
            if (funct7[6:1] == 6'h00)      dec_alu[ALU_SRL] = 1'b1;
            else if (funct7[6:1] == 6'h10) dec_alu[ALU_SRA] = 1'b1;
            else                           dec_illegal = 1'b1;
            if (XLEN == 32 && funct7[0]) dec_illegal = 1'b1;
          end
        endcase
      end
      7'h17: begin
        dec_op[3] = 1'b1; dec_rd_ena = 1'b1; dec_imm = imm_u; dec_alu[ALU_ADD] = 1'b1;
      end
      7'h1b: begin
        dec_op[4] = 1'b1; dec_rs1_ena = 1'b1; dec_rd_ena = 1'b1; dec_imm = imm_i;
        if (funct3 == 3'd0) dec_alu[ALU_ADD] = 1'b1;
        else if (funct3 == 3'd1 && funct7 == 7'h00) dec_alu[ALU_SLL] = 1'b1;
        else if (funct3 == 3'd5 && funct7 == 7'h00) dec_alu[ALU_SRL] = 1'b1;
        else if (funct3 == 3'd5 && funct7 == 7'h20) dec_alu[ALU_SRA] = 1'b1;
        else dec_illegal = 1'b1;
        if (XLEN == 32) dec_illegal = 1'b1;
      end
      7'h23: begin
        dec_op[5] = 1'b1; dec_rs1_ena = 1'b1; dec_rs2_ena = 1'b1;
        dec_imm = imm_s; dec_alu[ALU_ADD] = 1'b1;
        if (funct3[2]) dec_illegal = 1'b1;
        if (XLEN == 32 && funct3 == 3'd3) dec_illegal = 1'b1;
      end
      7'h33: begin
        dec_op[6] = 1'b1; dec_rs1_ena = 1'b1; dec_rs2_ena = 1'b1; dec_rd_ena = 1'b1;
        case (funct7)
          7'h00: begin
            case (funct3)
              3'd0:    dec_alu[ALU_ADD]  = 1'b1;
              3'd1:    dec_alu[ALU_SLL]  = 1'b1;
              3'd2:    dec_alu[ALU_SLT]  = 1'b1;
              3'd3:    dec_alu[ALU_SLTU] = 1'b1;
              3'd4:    dec_alu[ALU_XOR]  = 1'b1;
              3'd5:    dec_alu[ALU_SRL]  = 1'b1;
              3'd6:    dec_alu[ALU_OR]   = 1'b1;
              default: dec_alu[ALU_AND]  = 1'b1;
            endcase
          end
          7'h20: begin
            if (funct3 == 3'd0)      dec_alu[ALU_SUB] = 1'b1;
            else if (funct3 == 3'd5) dec_alu[ALU_SRA] = 1'b1;
            else                     dec_illegal = 1'b1;
          end
`ifdef ID_MEXT_EN
          7'h01: dec_mul[funct3] = 1'b1;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      7'h37: begin
        dec_op[7] = 1'b1; dec_rd_ena = 1'b1; dec_imm = imm_u; dec_alu[ALU_ADD] = 1'b1;
      end
      7'h3b: begin
        dec_op[8] = 1'b1; dec_rs1_ena = 1'b1; dec_rs2_ena = 1'b1; dec_rd_ena = 1'b1;
        case (funct7)
          7'h00: begin
            if (funct3 == 3'd0)      dec_alu[ALU_ADD] = 1'b1;
            else if (funct3 == 3'd1) dec_alu[ALU_SLL] = 1'b1;
            else if (funct3 == 3'd5) dec_alu[ALU_SRL] = 1'b1;
            else                     dec_illegal = 1'b1;
          end
          7'h20: begin
            if (funct3 == 3'd0)      dec_alu[ALU_SUB] = 1'b1;
            else if (funct3 == 3'd5) dec_alu[ALU_SRA] = 1'b1;
            else                     dec_illegal = 1'b1;
          end
`ifdef ID_MEXT_EN
          7'h01: begin
            if (funct3 == 3'd0 || funct3[2]) dec_mul[funct3] = 1'b1;
            else                             dec_illegal = 1'b1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
        if (XLEN == 32) dec_illegal = 1'b1;
      end
      7'h63: begin
        dec_op[9] = 1'b1; dec_rs1_ena = 1'b1; dec_rs2_ena = 1'b1; dec_imm = imm_b;
        case (funct3)
          3'd0, 3'd1: dec_alu[ALU_XOR]  = 1'b1;
          3'd4, 3'd5: dec_alu[ALU_SLT]  = 1'b1;
          3'd6, 3'd7: dec_alu[ALU_SLTU] = 1'b1;
          default:    dec_illegal = 1'b1;
        endcase
      end
      7'h67: begin
        dec_op[10] = 1'b1; dec_rs1_ena = 1'b1; dec_rd_ena = 1'b1;
        dec_imm = imm_i; dec_alu[ALU_ADD] = 1'b1;
        if (funct3 != 3'd0) dec_illegal = 1'b1;
      end
      7'h6f: begin
        dec_op[11] = 1'b1; dec_rd_ena = 1'b1; dec_imm = imm_j; dec_alu[ALU_ADD] = 1'b1;
      end
      7'h73: begin
        dec_op[12] = 1'b1; dec_imm = imm_i;
        if (funct3 == 3'd4) dec_illegal = 1'b1;
        else if (funct3 != 3'd0) begin
          dec_rd_ena  = 1'b1;
          dec_rs1_ena = !funct3[2];
        end
      end
      7'h6b: dec_op[13] = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_alu    = '0;
      dec_mul    = '0;
      dec_rd_ena = 1'b0;
    end
  end

  // Output slot: loads when the head can advance, holds while EX stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op_info  <= '0;
      out_alu_info <= '0;
      out_mul_info <= '0;
      out_rs1_addr <= '0;
      out_rs2_addr <= '0;
      out_rd_addr  <= '0;
      out_rs1_ena  <= 1'b0;
      out_rs2_ena  <= 1'b0;
      out_rd_ena   <= 1'b0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_pc       <= head_pc;
      out_op_info  <= dec_op;
      out_alu_info <= dec_alu;
      out_mul_info <= dec_mul;
      out_rs1_addr <= dec_rs1_ena ? head_inst[19:15] : 5'd0;
      out_rs2_addr <= dec_rs2_ena ? head_inst[24:20] : 5'd0;
      out_rd_addr  <= dec_rd_ena  ? head_inst[11:7]  : 5'd0;
      out_rs1_ena  <= dec_rs1_ena;
      out_rs2_ena  <= dec_rs2_ena;
      out_rd_ena   <= dec_rd_ena;
      out_imm      <= dec_imm;
      out_illegal  <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed bench for id_pipe_stage (XLEN=64 main instance,
// plus an XLEN=32 instance fed the same input stream for RV32 legality).
module tb_id_pipe_stage;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_ready, out_valid, out_rs1_ena, out_rs2_ena, out_rd_ena, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [13:0] out_op_info;
  logic [9:0]  out_alu_info;
  logic [7:0]  out_mul_info;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;

  logic        s32_in_ready, s32_out_valid, s32_rs1_ena, s32_rs2_ena, s32_rd_ena, s32_illegal;
  logic [31:0] s32_pc, s32_imm;
  logic [13:0] s32_op_info;
  logic [9:0]  s32_alu_info;
  logic [7:0]  s32_mul_info;
  logic [4:0]  s32_rs1_addr, s32_rs2_addr, s32_rd_addr;

  int total = 0;
  int bad   = 0;

  id_pipe_stage #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op_info(out_op_info), .out_alu_info(out_alu_info), .out_mul_info(out_mul_info),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_rs1_ena(out_rs1_ena), .out_rs2_ena(out_rs2_ena), .out_rd_ena(out_rd_ena),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  id_pipe_stage #(.XLEN(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s32_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(s32_out_valid), .out_ready(out_ready), .out_pc(s32_pc),
    .out_op_info(s32_op_info), .out_alu_info(s32_alu_info), .out_mul_info(s32_mul_info),
    .out_rs1_addr(s32_rs1_addr), .out_rs2_addr(s32_rs2_addr), .out_rd_addr(s32_rd_addr),
    .out_rs1_ena(s32_rs1_ena), .out_rs2_ena(s32_rs2_ena), .out_rd_ena(s32_rd_ena),
    .out_imm(s32_imm), .out_illegal(s32_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, then wait one more edge so it sits in the output slot
  task automatic send_one(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    #2 rst = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
    total++; if ({out_op_info, out_imm} !== 78'd0) begin bad++; $display("[TB] FAIL rst_fields: got op=%h imm=%h expected 0", out_op_info, out_imm); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_addi;
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h80000000;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_latency: got %b expected 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid: got %b expected 1", out_valid); end
    total++; if (out_pc !== 64'h80000000) begin bad++; $display("[TB] FAIL addi_pc: got %h expected 80000000", out_pc); end
    total++; if (out_op_info !== 14'h0004) begin bad++; $display("[TB] FAIL addi_op: got %h expected 0004", out_op_info); end
    total++; if (out_alu_info !== 10'h001) begin bad++; $display("[TB] FAIL addi_alu: got %h expected 001", out_alu_info); end
    total++; if ({out_rd_addr, out_rd_ena, out_rs1_ena, out_rs2_ena} !== {5'd1, 3'b110}) begin bad++; $display("[TB] FAIL addi_regs: got rd=%0d ena=%b%b%b expected rd=1 ena=110", out_rd_addr, out_rd_ena, out_rs1_ena, out_rs2_ena); end
    total++; if (out_imm !== 64'd5) begin bad++; $display("[TB] FAIL addi_imm: got %h expected 5", out_imm); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL addi_illegal: got %b expected 0", out_illegal); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_capacity;
    int acc;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_pc   = 64'h1000 + 64'(acc * 4);
      in_inst = 32'h13 | (32'(acc + 1) << 7);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (acc !== 5) begin bad++; $display("[TB] FAIL cap_accepted: got %0d expected 5", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL cap_full_ready: got %b expected 0", in_ready); end
    tick();
    total++; if (out_pc !== 64'h1000) begin bad++; $display("[TB] FAIL cap_hold: got %h expected 1000", out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL cap_valid%0d: got %b expected 1", k, out_valid); end
      total++; if (out_pc !== 64'h1000 + 64'(k * 4)) begin bad++; $display("[TB] FAIL cap_pc%0d: got %h expected %h", k, out_pc, 64'h1000 + 64'(k * 4)); end
      total++; if (out_rd_addr !== 5'(k + 1)) begin bad++; $display("[TB] FAIL cap_rd%0d: got %0d expected %0d", k, out_rd_addr, k + 1); end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL cap_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_inst = 32'h13 | (32'(k + 1) << 7);
      in_pc   = 64'h3000 + 64'(k * 4);
      tick();
    end
    total++; if (dut.count !== 3'd2) begin bad++; $display("[TB] FAIL flush_pre_count: got %0d expected 2", dut.count); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_valid: got %b expected 1", out_valid); end
    flush = 1'b1; in_inst = 32'h00700393; in_pc = 64'hDEAD0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); end
    total++; if (dut.count !== 3'd0) begin bad++; $display("[TB] FAIL flush_count: got %0d expected 0", dut.count); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_dropped%0d: got valid=%b pc=%h expected valid 0", k, out_valid, out_pc); end
    end
  endtask

  task automatic test_trap;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0000006b; in_pc = 64'h2000;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL trap_pre_ready: got %b expected 1", in_ready); end
    tick();
    in_inst = 32'h00100093; in_pc = 64'h2004;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL trap_halt_ready: got %b expected 0", in_ready); end
    tick();
    total++; if ({out_valid, out_op_info} !== {1'b1, 14'h2000}) begin bad++; $display("[TB] FAIL trap_op: got valid=%b op=%h expected 1/2000", out_valid, out_op_info); end
    total++; if ({out_illegal, out_rd_ena, out_pc} !== {2'b00, 64'h2000}) begin bad++; $display("[TB] FAIL trap_fields: got ill=%b rd_ena=%b pc=%h expected 0/0/2000", out_illegal, out_rd_ena, out_pc); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL trap_no_more: got %b expected 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL trap_still_halt: got %b expected 0", in_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL trap_flush_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_decode;
    out_ready = 1'b1;
    send_one(32'hFFFFFFFF, 64'h4000);
    total++; if ({out_valid, out_illegal, out_rd_ena} !== 3'b110) begin bad++; $display("[TB] FAIL ill_flags: got v=%b ill=%b rd_ena=%b expected 1/1/0", out_valid, out_illegal, out_rd_ena); end
    total++; if ({out_op_info, out_alu_info, out_mul_info} !== 32'd0) begin bad++; $display("[TB] FAIL ill_info: got op=%h alu=%h mul=%h expected 0", out_op_info, out_alu_info, out_mul_info); end
    send_one(32'h0000B003, 64'h4004);
    total++; if ({out_illegal, out_op_info, out_rd_ena} !== {1'b0, 14'h0001, 1'b1}) begin bad++; $display("[TB] FAIL ld64: got ill=%b op=%h rd_ena=%b expected 0/0001/1", out_illegal, out_op_info, out_rd_ena); end
    total++; if ({s32_out_valid, s32_illegal, s32_rd_ena} !== 3'b110) begin bad++; $display("[TB] FAIL ld32: got v=%b ill=%b rd_ena=%b expected 1/1/0", s32_out_valid, s32_illegal, s32_rd_ena); end
    send_one(32'h00208063, 64'h4008);
    total++; if ({out_op_info, out_alu_info} !== {14'h0200, 10'h010}) begin bad++; $display("[TB] FAIL beq_info: got op=%h alu=%h expected 0200/010", out_op_info, out_alu_info); end
    total++; if ({out_rs1_addr, out_rs2_addr, out_rd_ena} !== {5'd1, 5'd2, 1'b0}) begin bad++; $display("[TB] FAIL beq_regs: got rs1=%0d rs2=%0d rd_ena=%b expected 1/2/0", out_rs1_addr, out_rs2_addr, out_rd_ena); end
    send_one(32'hFE20AE23, 64'h400C);
    total++; if (out_imm !== 64'hFFFFFFFFFFFFFFFC) begin bad++; $display("[TB] FAIL sw_imm: got %h expected fffffffffffffffc", out_imm); end
    total++; if ({out_alu_info, out_rs2_ena, out_rd_ena} !== {10'h001, 2'b10}) begin bad++; $display("[TB] FAIL sw_info: got alu=%h rs2_ena=%b rd_ena=%b expected 001/1/0", out_alu_info, out_rs2_ena, out_rd_ena); end
    send_one(32'h800002B7, 64'h4010);
    total++; if (out_imm !== 64'hFFFFFFFF80000000) begin bad++; $display("[TB] FAIL lui_imm: got %h expected ffffffff80000000", out_imm); end
    total++; if (s32_imm !== 32'h80000000) begin bad++; $display("[TB] FAIL lui_imm32: got %h expected 80000000", s32_imm); end
  endtask

  task automatic test_mext;
    out_ready = 1'b1;
    send_one(32'h02208033, 64'h5000);
`ifdef ID_MEXT_EN
    total++; if ({out_illegal, out_mul_info} !== {1'b0, 8'h01}) begin bad++; $display("[TB] FAIL mul_info: got ill=%b mul=%h expected 0/01", out_illegal, out_mul_info); end
    total++; if ({out_rd_addr, out_rd_ena, out_rs1_ena, out_rs2_ena} !== {5'd0, 3'b111}) begin bad++; $display("[TB] FAIL mul_regs: got rd=%0d ena=%b%b%b expected 0/111", out_rd_addr, out_rd_ena, out_rs1_ena, out_rs2_ena); end
`else
    total++; if ({out_illegal, out_mul_info, out_rd_ena} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("[TB] FAIL mul_disabled: got ill=%b mul=%h rd_ena=%b expected 1/00/0", out_illegal, out_mul_info, out_rd_ena); end
`endif
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h6000;
    tick(); tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", out_valid); end
    #3 rst = 1'b1;
    #1;
    total++; if ({out_valid, out_pc, out_op_info, out_imm, out_rd_addr, out_rd_ena} !== 149'd0) begin bad++; $display("[TB] FAIL mid_rst_out: got v=%b pc=%h op=%h imm=%h expected all 0", out_valid, out_pc, out_op_info, out_imm); end
    total++; if ({in_ready, s32_out_valid} !== 2'b00) begin bad++; $display("[TB] FAIL mid_rst_ready: got ready=%b v32=%b expected 0/0", in_ready, s32_out_valid); end
    tick();
    rst = 1'b0;
    tick();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("[TB] FAIL mid_after_rst: got v=%b ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_addi();
    test_capacity();
    test_flush();
    test_trap();
    test_decode();
    test_mext();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
- Pipelined, parametrised successor to the single-cycle decode stage.
- Sits between IF and EX in the multi-cycle core.
- Buffers fetched instruction/PC pairs in an internal FIFO, decodes the FIFO head combinationally, and presents the results from a registered output slot.
- Handshakes are valid/ready on both sides. Supports flush, a termination halt, and illegal-instruction flagging.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- DEPTH, 4, input FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts; a transfer happens on an edge where in_valid & in_ready.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all buffered and output contents.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  EX consumes; a transfer happens on an edge where out_valid & out_ready.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_op_info  out  14  one-hot opcode class. Bits 0..13: load, fence, arith, auipc, arith_w, store, reg, lui, reg_w, branch, jalr, jal, sys, trap(0x6b).
- out_alu_info  out  10  one-hot ALU op. Bits 0..9: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA.
- out_mul_info  out  8  one-hot: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- out_rs1_addr / out_rs2_addr / out_rd_addr  out  5 each  register addresses; forced to 0 when the matching enable is 0.
- out_rs1_ena / out_rs2_ena / out_rd_ena  out  1 each  register read/write enables.
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate, selected by opcode class.
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset (async): FIFO empty, read/write pointers 0, state RUN. All out_* registers are 0; in_ready is 0 while rst is high.
- in_ready = (state==RUN) & (count<DEPTH). It is registered-count based: there is no same-cycle pass-through when full.
- FIFO write on an input transfer. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Output slot loads the decoded FIFO head on an edge where the FIFO is non-empty and (!out_valid | out_ready); the FIFO pops on that same edge.
- Simultaneous push and pop leaves count unchanged.
- Latency: an instruction accepted on edge E is visible on out_* after edge E+1 at the earliest.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Capacity: DEPTH+1 instructions in flight (FIFO plus output slot).
- Output holds stable while out_valid & !out_ready.
- flush has priority over everything on its edge:
  - FIFO emptied, out_valid cleared, state set to RUN.
  - An input transfer on the same edge is dropped.
- State machine:
  - RUN → HALT on the edge a trap opcode (0x6b) is accepted at the input.
  - In HALT, in_ready=0 and the FIFO drains normally, trap included.
  - HALT → RUN only on flush or rst.
- Decode rules:
  - Funct3/funct7 decode as the RV64I base.
  - Branches: ALU SUB for beq/bne is NOT used. beq/bne → XOR, blt/bge → SLT, bltu/bgeu → SLTU.
  - Loads, stores, auipc, lui, jal and jalr → ADD.
- Illegal (out_illegal=1, out_rd_ena=0, alu/mul info 0):
  - Unknown opcode.
  - Undefined funct3/funct7 combination.
  - Load funct3=7, or store funct3≥4.
- When XLEN==32, the following are also illegal:
  - opcodes 0x1b and 0x3b;
  - ld, lwu, sd;
  - shift immediates with inst[25]=1.
- Immediates sign-extend from their top bit to XLEN; U-type is {imm[31:12], 12'b0} sign-extended.

Optional Feature:
- Macro ID_MEXT_EN.
- Defined: opcode 0x33/0x3b with funct7=0x01 decodes to out_mul_info (W forms set arith_w/reg_w in op_info), with rs1/rs2/rd enables set.
- Undefined: out_mul_info is tied to 0 and those encodings raise out_illegal.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) at pc 0x80000000, out_ready=1 → after 2 edges: out_valid=1, alu bit0, rd=1, rs1_ena=1, rs2_ena=0, imm=5.
- out_ready=0, in_valid=1 continuously, DEPTH=4 → exactly 5 accepted, then in_ready=0. Raise out_ready → 5 outputs in order, 1 per cycle, PCs ascending.
- Fill 3 entries, pulse flush concurrent with an input transfer → next cycle out_valid=0, count=0; the dropped instruction never appears.
- Input 0x0000006b, then more in_valid → in_ready=0 after the trap is accepted; trap emerges with op_info bit13=1; in_ready stays 0 until flush.
- 0xFFFFFFFF → out_illegal=1, rd_ena=0. With XLEN=32, 0x0000B003 (ld) → out_illegal=1.
- 0x02208033 (mul x0,x1,x2): with ID_MEXT_EN → mul_info bit0=1, rd_addr=0 and rd_ena=1; without it → out_illegal=1. Assert rst mid-stream → all outputs 0 immediately.
